// File: rtl/snoop_emitter_mesi.sv
// snoop_emitter_mesi: requesting-side MESI coherence controller for one
// private cache of LINES lines. Local hits retire without the bus; misses and
// S-state write hits arbitrate for the bus and emit one message in XFER.
// Remote invalidates may downgrade any line at any time.
module snoop_emitter_mesi #(
  parameter int IDX_W = 2
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Valid,
  input  logic [1:0]       i_Operation,
  input  logic [IDX_W-1:0] i_Idx,
  output logic             o_Ready,
  output logic             o_Done,
  output logic             o_BusReq,
  input  logic             i_BusGrant,
  output logic [1:0]       o_BusMsg,
  output logic [IDX_W-1:0] o_BusIdx,
  output logic             o_WriteBack,
  input  logic             i_Shared,
  input  logic             i_SnoopInv,
  input  logic [IDX_W-1:0] i_SnoopIdx,
  output logic [1:0]       o_State
);

  localparam int unsigned LINES = 2 ** IDX_W;

  typedef enum logic [1:0] {ST_I = 2'b00, ST_S = 2'b01, ST_E = 2'b10, ST_M = 2'b11} mesi_e;
  typedef enum logic [1:0] {OP_RM = 2'b00, OP_RH = 2'b01, OP_WM = 2'b10, OP_WH = 2'b11} op_e;
  typedef enum logic [1:0] {MSG_NONE = 2'b00, MSG_RDMISS = 2'b01, MSG_WRMISS = 2'b10, MSG_INV = 2'b11} msg_e;
  typedef enum logic [1:0] {FSM_IDLE = 2'b00, FSM_REQ = 2'b01, FSM_XFER = 2'b10} fsm_e;

  mesi_e            r_Mesi [LINES];
  fsm_e             r_Fsm;
  fsm_e             w_FsmNext;
  op_e              r_Op;
  logic [IDX_W-1:0] r_Idx;
  logic             r_Done;

  op_e   w_Op;
  mesi_e w_CurSt;
  mesi_e w_XferSt;
  logic  w_Accept;
  logic  w_LocalHit;
  op_e   w_BusOp;
  msg_e  w_Msg;
  mesi_e w_XferNewSt;

  assign w_Op     = op_e'(i_Operation);
  assign w_CurSt  = r_Mesi[i_Idx];
  assign w_XferSt = r_Mesi[r_Idx];
  assign w_Accept = (r_Fsm == FSM_IDLE) && i_Valid;

  assign o_State  = w_CurSt;
  assign o_Done   = r_Done;
  assign o_BusMsg = w_Msg;

  // Classify the presented op against the line state and pick the bus flavour
  always_comb begin
    w_LocalHit = 1'b0;
    w_BusOp    = OP_RM;
    case (w_Op)
      OP_RM: w_BusOp = OP_RM;
      OP_RH: begin
        w_LocalHit = (w_CurSt != ST_I);
        w_BusOp    = OP_RM;
      end
      OP_WM: w_BusOp = OP_WM;
      OP_WH: begin
        w_LocalHit = (w_CurSt == ST_E) || (w_CurSt == ST_M);
        // A write hit on I degenerates to a write miss; on S it needs an upgrade
        w_BusOp    = (w_CurSt == ST_I) ? OP_WM : OP_WH;
      end
      default: ;
    endcase
  end

  // Next-state and bus-side outputs
  always_comb begin
    w_FsmNext   = r_Fsm;
    o_Ready     = 1'b0;
    o_BusReq    = 1'b0;
    w_Msg       = MSG_NONE;
    o_BusIdx    = '0;
    o_WriteBack = 1'b0;
    w_XferNewSt = ST_M;
    case (r_Fsm)
      FSM_IDLE: begin
        o_Ready = !i_Reset;
        if (i_Valid && !w_LocalHit) w_FsmNext = FSM_REQ;
      end
      FSM_REQ: begin
        o_BusReq = 1'b1;
        o_BusIdx = r_Idx;
        if (i_BusGrant) w_FsmNext = FSM_XFER;
      end
      FSM_XFER: begin
        o_BusIdx    = r_Idx;
        o_WriteBack = (w_XferSt == ST_M);
        // Message follows the line's present state: a snoop during REQ may
        // have turned a pending S upgrade into a full write miss
        case (r_Op)
          OP_RM:   w_Msg = MSG_RDMISS;
          OP_WH:   w_Msg = (w_XferSt == ST_S) ? MSG_INV : MSG_WRMISS;
          default: w_Msg = MSG_WRMISS;
        endcase
        w_XferNewSt = (r_Op == OP_RM) ? (i_Shared ? ST_S : ST_E) : ST_M;
        w_FsmNext   = FSM_IDLE;
      end
      default: w_FsmNext = FSM_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_Clock) begin
    if (i_Reset) r_Fsm <= FSM_IDLE;
    else         r_Fsm <= w_FsmNext;
  end

  // Latch the pending bus operation and its line at acceptance
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Op  <= OP_RM;
      r_Idx <= '0;
    end else if (w_Accept && !w_LocalHit) begin
      r_Op  <= w_BusOp;
      r_Idx <= i_Idx;
    end
  end

  // Retire pulse one cycle after a local hit or a bus transfer
  always_ff @(posedge i_Clock) begin
    if (i_Reset) r_Done <= 1'b0;
    else         r_Done <= (w_Accept && w_LocalHit) || (r_Fsm == FSM_XFER);
  end

  // Line state array; the later assignments override a same-line snoop
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      for (int unsigned k = 0; k < LINES; k++) r_Mesi[k] <= ST_I;
    end else begin
      if (i_SnoopInv) r_Mesi[i_SnoopIdx] <= ST_I;
      if (w_Accept && w_LocalHit && (w_Op == OP_WH)) r_Mesi[i_Idx] <= ST_M;
      if (r_Fsm == FSM_XFER) r_Mesi[r_Idx] <= w_XferNewSt;
    end
  end

endmodule

// File: doc/snoop_emitter_mesi.md
Name: snoop_emitter_mesi

Overview:
- Requesting-side coherence controller for one private cache. It holds per-line MESI state for LINES lines.
- It classifies processor operations (read/write, hit/miss) and emits the matching bus message through a request/grant handshake. Local-only operations complete without the bus.
- It is the parametrised successor of the single-line MSI emitter. It adds the Exclusive state, multiple lines, bus arbitration, writeback flagging and remote invalidation.

Parameters:
IDX_W, 2, line index width; LINES = 2**IDX_W

Ports:
i_Clock  in  1  clock, rising edge
i_Reset  in  1  synchronous, active-high reset
i_Valid  in  1  processor operation valid
i_Operation  in  2  00 RM, 01 RH, 10 WM, 11 WH
i_Idx  in  IDX_W  target line
o_Ready  out  1  operation accepted when i_Valid && o_Ready
o_Done  out  1  one-cycle pulse: operation retired
o_BusReq  out  1  bus request
i_BusGrant  in  1  bus grant
o_BusMsg  out  2  00 NONE, 01 READ_MISS, 10 WRITE_MISS, 11 INVALIDATE
o_BusIdx  out  IDX_W  line of current bus message
o_WriteBack  out  1  victim Modified; data write-back accompanies message
i_Shared  in  1  other cache holds the line; sampled in XFER
i_SnoopInv  in  1  remote invalidate request
i_SnoopIdx  in  IDX_W  line to invalidate
o_State  out  2  combinational state of line i_Idx: 00 I, 01 S, 10 E, 11 M

Behaviour:
- Reset (on clock edge while i_Reset=1):
  - All lines go to I and the FSM goes to IDLE.
  - o_Done, o_BusReq, o_WriteBack = 0; o_BusMsg = NONE; o_BusIdx = 0.
  - o_Ready = 0 while i_Reset is high and 1 in the first cycle after.
  - Reset mid-operation aborts the operation. No o_Done is issued and o_BusReq drops at that edge.
- FSM states: IDLE, REQ, XFER.
- IDLE:
  - o_Ready = 1.
  - An op is accepted at the edge where i_Valid=1. The op, i_Idx and the classification are latched.
- Classification uses the line state at acceptance:
  - RH on S/E/M: local; state unchanged.
  - WH on E/M: local; state becomes M (silent E->M upgrade).
  - RH on I is treated as RM. WH on I is treated as WM.
  - RM, WM, and WH on S need the bus.
- Local ops:
  - The state updates at the acceptance edge.
  - o_Done = 1 in the next cycle.
  - The FSM stays in IDLE, so back-to-back local ops are possible every cycle.
- Bus ops: the FSM goes from IDLE to REQ.
- REQ:
  - o_Ready = 0 and o_BusReq = 1, held until i_BusGrant=1 is sampled; then the FSM goes to XFER.
  - There is no timeout. A grant outside REQ is ignored.
- XFER (exactly 1 cycle):
  - o_BusReq = 0; o_BusMsg, o_BusIdx and o_WriteBack are valid.
  - The message is re-derived from the line's current state, which may have been snooped to I while waiting:
    - RM: READ_MISS.
    - WM: WRITE_MISS.
    - WH: INVALIDATE if the line is still S; WRITE_MISS if it is now I.
  - o_WriteBack = 1 only when the line is currently M, which is possible for a miss treated as a replacement.
  - At the XFER edge:
    - RM -> E if i_Shared=0, else S.
    - WM/WH -> M.
  - The FSM returns to IDLE with o_Done = 1 in the following cycle. o_BusMsg returns to NONE.
- Snoop invalidate:
  - i_SnoopInv=1 sets line i_SnoopIdx to I at the next edge, in any FSM state.
  - If the snoop targets the same line as an update at that edge (local op or XFER), the local update wins.
  - Snoops to other lines at the same edge both take effect.
- i_Operation and i_Idx are don't-care when not accepted.

Test Plan:
1. Reset, then RM idx 1, grant 2 cycles after request, i_Shared=0 -> REQ for 2 cycles, then XFER with READ_MISS idx 1 and WriteBack=0; line 1 = E; o_Done the cycle after XFER.
2. RH idx 1 then WH idx 1 back-to-back -> no o_BusReq; o_Done pulses in 2 consecutive cycles; line 1 = M.
3. RM idx 2 with i_Shared=1, then WH idx 2 -> first op leaves S; second op sends INVALIDATE idx 2 with WriteBack=0; line 2 = M.
4. Line 3 in S; WH idx 3 accepted; i_SnoopInv idx 3 asserted in REQ before grant -> XFER sends WRITE_MISS, not INVALIDATE; line 3 = M.
5. Line 0 in M; WM idx 0 -> XFER WRITE_MISS with o_WriteBack=1; line 0 = M. Concurrent snoop on idx 0 at the XFER edge -> line 0 stays M.
6. i_Reset asserted while in REQ -> o_BusReq=0 next cycle, no o_Done, all o_State = I, o_Ready=1 after release.
